// File: rtl/aq_djpeg_pkg.sv
// Shared types for the JPEG decoder frame-buffer writer: FSM state encoding and write-FIFO entry.
// Address field is 32 bits wide, so the writer supports ADDR_W up to 32.
package aq_djpeg_pkg;

    localparam int FB_ADDR_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fb_state_e;

    typedef struct packed {
        logic [FB_ADDR_MAX-1:0] addr;
        logic [31:0]            data;
    } fb_entry_t;

endpackage

// File: rtl/aq_djpeg_fbwrite_fifo.sv
// Synchronous write FIFO of fb_entry_t; head is read straight from registered storage, zero when empty.
// Latency 1 cycle push-to-visible; a push on full is taken only if a pop happens in the same cycle.
module aq_djpeg_fbwrite_fifo
    import aq_djpeg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_vld,
    input  fb_entry_t push_dat,
    input  logic      pop_rdy,
    output fb_entry_t pop_dat,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_fire;
    logic          push_fire;
    fb_entry_t     mem_q [DEPTH];

    always_comb begin
        empty     = (cnt_q == '0);
        full      = (cnt_q == CW'(DEPTH));
        pop_fire  = pop_rdy && !empty;
        push_fire = push_vld && (!full || pop_fire);
        // Power-of-two depth: pointers wrap by plain overflow.
        wr_ptr_d  = wr_ptr_q + AW'(push_fire);
        rd_ptr_d  = rd_ptr_q + AW'(pop_fire);
        cnt_d     = cnt_q + CW'(push_fire) - CW'(pop_fire);
        pop_dat   = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/aq_djpeg_fbwrite.sv
// Decoder pixel -> frame-buffer write engine; PixelEnable to earliest WrReq is 2 cycles, WrReq/WrAck backpressure,
// overflowing pixels dropped with sticky Overflow. AQ_DJPEG_FBWRITE_STATUS_EN adds PixelCount/DropCount.
module aq_djpeg_fbwrite
    import aq_djpeg_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Enable,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [15:0]       Stride,
    input  logic              PixelEnable,
    input  logic [15:0]       PixelWidth,
    input  logic [15:0]       PixelHeight,
    input  logic [15:0]       PixelX,
    input  logic [15:0]       PixelY,
    input  logic [7:0]        PixelR,
    input  logic [7:0]        PixelG,
    input  logic [7:0]        PixelB,
    output logic              WrReq,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [31:0]       WrData,
    input  logic              WrAck,
    output logic              Busy,
    output logic              FrameDone,
    output logic              Overflow,
`ifdef AQ_DJPEG_FBWRITE_STATUS_EN
    output logic [31:0]       PixelCount,
    output logic [15:0]       DropCount,
`endif
    input  logic              Clear
);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       stride_q, stride_d;
    fb_entry_t         stage_q, stage_d;
    logic              stage_vld_q, stage_vld_d;
    logic              ovf_q, ovf_d;

    logic              pix_acc;
    logic              last_px;
    logic              pop;
    logic              drop;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] addr_calc;
    logic              fifo_full;
    logic              fifo_empty;
    fb_entry_t         fifo_head;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        stride_d    = stride_q;
        stage_d     = stage_q;
        stage_vld_d = 1'b0;

        pix_acc   = (state_q == ST_RUN) && PixelEnable;
        last_px   = (PixelX == PixelWidth - 16'd1) && (PixelY == PixelHeight - 16'd1);
        pop       = !fifo_empty && WrAck;
        drop      = stage_vld_q && fifo_full && !pop;
        offset    = 32'(PixelY) * 32'(stride_q) + {14'd0, PixelX, 2'b00};
        addr_calc = base_q + ADDR_W'(offset);
        ovf_d     = (ovf_q && !Clear) || drop;

        if (pix_acc) begin
            stage_vld_d  = 1'b1;
            stage_d.addr = FB_ADDR_MAX'(addr_calc);
            stage_d.data = {8'h00, PixelR, PixelG, PixelB};
        end

        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d  = ST_RUN;
                    base_d   = BaseAddr;
                    stride_d = Stride;
                end
            end
            ST_RUN: begin
                if ((pix_acc && last_px) || !Enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!stage_vld_q && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            stride_q    <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            ovf_q       <= ovf_d;
        end
    end

    aq_djpeg_fbwrite_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (stage_vld_q),
        .push_dat (stage_q),
        .pop_rdy  (WrAck),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign WrReq     = !fifo_empty;
    assign WrAddr    = fifo_head.addr[ADDR_W-1:0];
    assign WrData    = fifo_head.data;
    assign Busy      = (state_q != ST_IDLE);
    assign FrameDone = (state_q == ST_DONE);
    assign Overflow  = ovf_q;

`ifdef AQ_DJPEG_FBWRITE_STATUS_EN
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pix_cnt_d  = pix_cnt_q + 32'(pop);
        drop_cnt_d = drop_cnt_q;
        if (state_q == ST_IDLE && Enable) begin
            pix_cnt_d = '0;
        end
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign PixelCount = pix_cnt_q;
    assign DropCount  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_aq_djpeg_fbwrite.sv
// Scoreboard bench for aq_djpeg_fbwrite: expected writes queued at pixel drive, compared on each WrReq&WrAck.
module tb_aq_djpeg_fbwrite;

    logic        clk = 1'b0;
    logic        rst;
    logic        Enable;
    logic [31:0] BaseAddr;
    logic [15:0] Stride;
    logic        PixelEnable;
    logic [15:0] PixelWidth, PixelHeight, PixelX, PixelY;
    logic [7:0]  PixelR, PixelG, PixelB;
    logic        WrReq;
    logic [31:0] WrAddr;
    logic [31:0] WrData;
    logic        WrAck;
    logic        Busy, FrameDone, Overflow, Clear;

    always #5 clk = ~clk;

    aq_djpeg_fbwrite dut (
        .clk         (clk),
        .rst         (rst),
        .Enable      (Enable),
        .BaseAddr    (BaseAddr),
        .Stride      (Stride),
        .PixelEnable (PixelEnable),
        .PixelWidth  (PixelWidth),
        .PixelHeight (PixelHeight),
        .PixelX      (PixelX),
        .PixelY      (PixelY),
        .PixelR      (PixelR),
        .PixelG      (PixelG),
        .PixelB      (PixelB),
        .WrReq       (WrReq),
        .WrAddr      (WrAddr),
        .WrData      (WrData),
        .WrAck       (WrAck),
        .Busy        (Busy),
        .FrameDone   (FrameDone),
        .Overflow    (Overflow),
        .Clear       (Clear)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Monitor sits on the falling edge; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (FrameDone) fd_cnt++;
            if (WrReq && WrAck) begin
                if (sb_q.size() == 0) check("sb_underflow", 64'(sb_q.size()), 64'd1);
                else check("wr", {WrAddr, WrData}, sb_q.pop_front());
                wr_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [15:0] x, input logic [15:0] y);
        return BaseAddr + 32'(y) * 32'(Stride) + 32'(x) * 32'd4;
    endfunction

    task automatic px(input logic [15:0] x, input logic [15:0] y,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input bit expect_wr);
        PixelX = x; PixelY = y; PixelR = r; PixelG = g; PixelB = b;
        PixelEnable = 1'b1;
        if (expect_wr) sb_q.push_back({exp_addr(x, y), 8'h00, r, g, b});
        tick();
        PixelEnable = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                               input logic [15:0] w, input logic [15:0] h);
        BaseAddr = base; Stride = stride; PixelWidth = w; PixelHeight = h;
        wr_cnt = 0;
        fd_cnt = 0;
        Enable = 1'b1;
        tick();
        check("busy_run", Busy, 1);
    endtask

    task automatic wait_writes(input string tag, input int n);
        for (int i = 0; i < 500 && wr_cnt < n; i++) tick();
        repeat (3) tick();
        check({tag, "_writes"}, 64'(wr_cnt), 64'(n));
        check({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (FrameDone) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_at_done"}, Busy, 1);
        tick();
        check({tag, "_busy_after"}, Busy, 0);
        check({tag, "_done_after"}, FrameDone, 0);
    endtask

    initial begin
        rst = 1'b0; Enable = 1'b0; BaseAddr = '0; Stride = '0; PixelEnable = 1'b0;
        PixelWidth = '0; PixelHeight = '0; PixelX = '0; PixelY = '0;
        PixelR = '0; PixelG = '0; PixelB = '0; WrAck = 1'b0; Clear = 1'b0;
        repeat (3) tick();
        check("rst_wrreq", WrReq, 0);
        check("rst_busy", Busy, 0);
        check("rst_framedone", FrameDone, 0);
        check("rst_overflow", Overflow, 0);
        check("rst_wraddr", WrAddr, 0);
        check("rst_wrdata", WrData, 0);
        rst = 1'b1;
        tick();

        // Basic write and 2-cycle latency
        WrAck = 1'b1;
        start_frame(32'h1000_0000, 16'd64, 16'd16, 16'd16);
        px(16'd3, 16'd2, 8'h11, 8'h22, 8'h33, 1'b1);
        check("lat1_wrreq", WrReq, 0);
        tick();
        check("lat2_wrreq", WrReq, 1);
        check("basic_addr", WrAddr, 32'h1000_008C);
        check("basic_data", WrData, 32'h0011_2233);
        wait_writes("basic", 1);
        Enable = 1'b0;
        wait_done("basic");

        // 4x2 frame: last pixel ends the frame while Enable stays high
        start_frame(32'h2000_0000, 16'd128, 16'd4, 16'd2);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                px(16'(x), 16'(y), 8'(x * 16 + y), 8'(x + 5), 8'(y + 9), 1'b1);
        wait_done("frame");
        Enable = 1'b0;
        check("frame_fd_once", 64'(fd_cnt), 64'd1);
        check("frame_writes", 64'(wr_cnt), 64'd8);

        // Backpressure and overflow
        WrAck = 1'b0;
        start_frame(32'h3000_0000, 16'd256, 16'd64, 16'd4);
        for (int i = 0; i < 17; i++)
            px(16'(i), 16'd0, 8'(i), 8'(i + 1), 8'(i + 2), i < 16);
        tick();
        check("bp_overflow", Overflow, 1);
        check("bp_wrreq", WrReq, 1);
        check("bp_head", WrAddr, 32'h3000_0000);
        WrAck = 1'b1;
        wait_writes("bp", 16);
        check("bp_overflow_sticky", Overflow, 1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_overflow", Overflow, 0);
        Enable = 1'b0;
        wait_done("bp");

        // Full FIFO with a pop in the same cycle as the push
        WrAck = 1'b0;
        start_frame(32'h4000_0000, 16'd256, 16'd64, 16'd4);
        for (int i = 0; i < 16; i++)
            px(16'(i), 16'd1, 8'(i), 8'hA0, 8'h0B, 1'b1);
        tick();
        px(16'd16, 16'd1, 8'h77, 8'h66, 8'h55, 1'b1);
        WrAck = 1'b1;
        tick();
        WrAck = 1'b0;
        check("fp_overflow", Overflow, 0);
        WrAck = 1'b1;
        wait_writes("fp", 17);
        Enable = 1'b0;
        wait_done("fp");

        // Reset mid-frame with pending writes
        WrAck = 1'b0;
        start_frame(32'h5000_0000, 16'd64, 16'd64, 16'd4);
        for (int i = 0; i < 5; i++)
            px(16'(i), 16'd0, 8'(i), 8'h01, 8'h02, 1'b0);
        repeat (2) tick();
        check("rm_wrreq_pre", WrReq, 1);
        rst = 1'b0;
        Enable = 1'b0;
        tick();
        check("rm_wrreq", WrReq, 0);
        check("rm_busy", Busy, 0);
        rst = 1'b1;
        WrAck = 1'b1;
        repeat (3) tick();
        check("rm_wrreq_quiet", WrReq, 0);

        // Clean frame after reset; address wraps modulo 2^32
        start_frame(32'hFFFF_FFF0, 16'd64, 16'd16, 16'd16);
        WrAck = 1'b0;
        px(16'd8, 16'd0, 8'hAA, 8'hBB, 8'hCC, 1'b1);
        tick();
        check("wrap_addr", WrAddr, 32'h0000_0010);
        check("wrap_data", WrData, 32'h00AA_BBCC);
        WrAck = 1'b1;
        wait_writes("wrap", 1);
        Enable = 1'b0;
        wait_done("wrap");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
